uart_fifo_buffer: RTL and testbench
===================================

# uart_fifo_buffer

Parametrised synchronous FIFO with integrated storage, occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It buffers UART RX and TX bytes between the shift-register datapaths and the bus-interface registers. It replaces the bare register-file-plus-external-controller arrangement with a single self-contained block.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH
- AF_LEVEL, 2**ADDR_WIDTH-2, almost_full asserts when level >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr  in  1  write request
- w_data  in  DATA_WIDTH  write data
- rd  in  1  read/pop request
- r_data  out  DATA_WIDTH  read data
- r_valid  out  1  r_data is valid
- full  out  1  level == depth
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- level  out  ADDR_WIDTH+1  current occupancy, 0..depth
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow and underflow

## Operation
- Write and read pointers are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address storage, and the MSB disambiguates full from empty. Pointers wrap naturally from depth*2-1 to 0.
- A write is accepted when wr && !full. Storage[wptr] <= w_data and wptr increments.
- A read is accepted when rd && !empty, and rptr increments.
- Simultaneous rd and wr:
  - When neither full nor empty, both are accepted and level is unchanged.
  - When empty, only the write is accepted (level 0->1).
  - When full, only the read is accepted (level depth->depth-1). The write is dropped and overflow is set.
- level, full, empty, almost_full and almost_empty are registered. They are derived from the pointer state and reflect all accepted operations from the previous edge.
- overflow is set on wr && full. underflow is set on rd && empty.
- clr_err clears both error flags. If a new error occurs in the same cycle as clr_err, the set wins.
- Storage is not reset; pointers, flags and r_data are.
- Reset values: r_data=0, r_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, level=0, overflow=0, underflow=0.
- Asserting reset_n low mid-operation immediately discards all contents and forces the reset values. Any transfer in that cycle is lost.

## Timing
- Write to visibility: a write on edge N deasserts empty and increments level after edge N. The word is readable from cycle N+1.
- Pop updates level and full after the same edge.
- Flags never lag pointers; there are no combinational paths from wr/rd to the status outputs.
- r_data and r_valid timing depends on configuration (see below).
- Throughput: one write and one read per cycle sustained.

## Configuration
- Macro: UART_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - r_data continuously shows storage[rptr] and r_valid = !empty.
  - rd acknowledges the shown word, and the next word appears after the edge.
  - r_data is forced to 0 while empty.
- Undefined (registered read):
  - An accepted read on edge N loads r_data <= storage[rptr] and pulses r_valid high for cycle N+1 only.
  - r_data holds its last value otherwise.
  - A rejected read (empty) leaves r_valid low.

## Test plan
- Reset, then depth=16 with 16 writes of 0x00..0x0F: full=1, level=16, almost_full=1 from level 14. A 17th write sets overflow=1 and leaves the contents intact.
- 16 reads after fill: data returned 0x00..0x0F in order, empty=1 after the last read. One more rd sets underflow=1 and r_valid stays 0.
- Simultaneous wr+rd at level 5 for 40 cycles (multiple pointer wraps): level stays 5 and data order is preserved.
- Simultaneous wr+rd when empty: level goes to 1 and no underflow. Simultaneous wr+rd when full: level goes to 15 and overflow=1.
- clr_err asserted alone clears both flags. clr_err in the same cycle as wr-while-full leaves overflow=1.
- reset_n pulsed low mid-burst at level 9: all outputs show reset values asynchronously, and the following write/read returns only the new data. Run with and without UART_FIFO_FWFT_EN to check r_valid latency of 0 vs 1 cycle.

Source files
------------

// File: rtl/uart_fifo_buffer.sv
// uart_fifo_buffer: synchronous FIFO that sits between the UART shift-register
// datapaths and the bus-interface registers. It provides an occupancy count,
// programmable almost-full/almost-empty flags and sticky overflow/underflow
// error flags.
// Optional feature macro: UART_FIFO_FWFT_EN selects first-word-fall-through
// read data. When the macro is not defined, the read port is registered.
module uart_fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_L    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_L    = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                af_q, af_d, ae_q, ae_d;
  logic                ovf_q, ovf_d, udf_q, udf_d;
  logic                wr_acc, rd_acc;

  // Accept decisions, pointer advance and status flags computed from the
  // pointers as they will be after this edge, so the flags never lag the pointers.
  always_comb begin
    wr_acc  = wr && !full_q;
    rd_acc  = rd && !empty_q;
    wptr_d  = wr_acc ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = rd_acc ? rptr_q + PTR_ONE : rptr_q;
    level_d = wptr_d - rptr_d;
    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == '0);
    af_d    = (level_d >= AF_L);
    ae_d    = (level_d <= AE_L);
  end

  // Sticky error flags. A new error in the same cycle as clr_err keeps the flag set.
  // A read against an empty FIFO that coincides with a write is not counted as an
  // underflow, because the write fills the FIFO on that edge.
  always_comb begin
    ovf_d = clr_err ? 1'b0 : ovf_q;
    udf_d = clr_err ? 1'b0 : udf_q;
    if (wr && full_q) ovf_d = 1'b1;
    if (rd && empty_q && !wr) udf_d = 1'b1;
  end

  // Storage array. It has no reset; only the pointers define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q[ADDR_WIDTH-1:0]] <= w_data;
  end

  // Pointer and status register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

`ifdef UART_FIFO_FWFT_EN
  // The head word is shown continuously. r_data is forced to zero while the FIFO is empty.
  assign r_data  = empty_q ? '0 : mem[rptr_q[ADDR_WIDTH-1:0]];
  assign r_valid = !empty_q;
`else
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  r_valid_q, r_valid_d;

  // Registered read port. It loads only on an accepted pop and holds its value otherwise.
  always_comb begin
    r_data_d  = rd_acc ? mem[rptr_q[ADDR_WIDTH-1:0]] : r_data_q;
    r_valid_d = rd_acc;
  end

  // Read data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
`endif

endmodule

// File: tb/tb_uart_fifo_buffer.sv
// Testbench for uart_fifo_buffer. It contains a queue-based reference model that is
// compared against the DUT on every falling edge. Literal checks are placed at the
// key points of the scenario to pin the model.
module tb_uart_fifo_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr, rd, clr_err;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       r_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] level;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  logic [7:0] q[$];
  logic       m_ovf, m_udf, m_rv;
  logic [7:0] m_rd;

  uart_fifo_buffer dut (
    .clk(clk), .reset_n(rst_n), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a FIFO queue together with the sticky error and read-port behaviour.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf <= 1'b0;
      m_udf <= 1'b0;
      m_rv  <= 1'b0;
      m_rd  <= '0;
    end else begin
      if (clr_err) begin
        m_ovf <= 1'b0;
        m_udf <= 1'b0;
      end
      if (wr && q.size() == DEPTH) m_ovf <= 1'b1;
      if (rd && q.size() == 0 && !wr) m_udf <= 1'b1;
      m_rv <= rd && q.size() != 0;
      if (rd && q.size() != 0) m_rd <= q[0];
      if (wr && q.size() < DEPTH) begin
        if (rd && q.size() != 0) void'(q.pop_front());
        q.push_back(w_data);
      end else if (rd && q.size() != 0) begin
        void'(q.pop_front());
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_level", {27'd0, level}, q.size());
      chk("m_full", full, q.size() == DEPTH);
      chk("m_empty", empty, q.size() == 0);
      chk("m_afull", almost_full, q.size() >= DEPTH - 2);
      chk("m_aempty", almost_empty, q.size() <= 2);
      chk("m_ovf", overflow, m_ovf);
      chk("m_udf", underflow, m_udf);
`ifdef UART_FIFO_FWFT_EN
      chk("m_rvalid", r_valid, q.size() != 0);
      chk("m_rdata", r_data, (q.size() != 0) ? q[0] : 8'h00);
`else
      chk("m_rvalid", r_valid, m_rv);
      chk("m_rdata", r_data, m_rd);
`endif
    end
  end

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    @(negedge clk);
    #2;
    wr = w; w_data = d; rd = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_rdata"}, r_data, 8'h00);
    chk({tag, "_rvalid"}, r_valid, 1'b0);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_afull"}, almost_full, 1'b0);
    chk({tag, "_aempty"}, almost_empty, 1'b1);
    chk({tag, "_level"}, {27'd0, level}, 0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_udf"}, underflow, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_d;
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; w_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    reset_vals("rst");
    chk_en = 1'b1;

    // Fill to depth with 0x00..0x0F.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_level", {27'd0, level}, i + 1);
      chk("fill_afull", almost_full, (i + 1) >= 14);
      chk("fill_aempty", almost_empty, (i + 1) <= 2);
`ifdef UART_FIFO_FWFT_EN
      if (i == 0) chk("fwft_rvalid_lat0", r_valid, 1'b1);
`else
      if (i == 0) chk("reg_rvalid_nowr", r_valid, 1'b0);
`endif
    end
    chk("fill_full", full, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("wr_full_ovf", overflow, 1'b1);
    chk("wr_full_level", {27'd0, level}, 16);

    // Drain and check the order.
    for (int i = 0; i < DEPTH; i++) begin
`ifdef UART_FIFO_FWFT_EN
      chk("drain_data", r_data, 8'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
`else
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_rvalid", r_valid, 1'b1);
      chk("drain_data", r_data, 8'(i));
`endif
    end
    chk("drain_empty", empty, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rd_empty_udf", underflow, 1'b1);
    chk("rd_empty_rvalid", r_valid, 1'b0);

    // clr_err alone clears both flags.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_udf", underflow, 1'b0);

    // Simultaneous write and read while empty.
    step(1'b1, 8'h33, 1'b1, 1'b0);
    chk("wr_rd_empty_level", {27'd0, level}, 1);
    chk("wr_rd_empty_udf", underflow, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    chk("lvl5", {27'd0, level}, 5);

    // Sustained write and read at level 5 across several pointer wraps.
    for (int i = 0; i < 40; i++) begin
      if (i == 0) exp_d = 8'h33;
      else if (i < 5) exp_d = 8'h50 + 8'(i - 1);
      else exp_d = 8'h80 + 8'(i - 5);
`ifdef UART_FIFO_FWFT_EN
      chk("stream_data", r_data, exp_d);
      step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
`else
      step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
      chk("stream_data", r_data, exp_d);
`endif
      chk("stream_level", {27'd0, level}, 5);
    end

    // Simultaneous write and read while full.
    for (int i = 0; i < 11; i++) step(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
    chk("refill_full", full, 1'b1);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("wr_rd_full_level", {27'd0, level}, 15);
    chk("wr_rd_full_ovf", overflow, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr2_ovf", overflow, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    chk("refull_level", {27'd0, level}, 16);
    step(1'b1, 8'hCC, 1'b0, 1'b1);
    chk("set_wins_ovf", overflow, 1'b1);
    chk("set_wins_level", {27'd0, level}, 16);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Drain to level 9, then pulse reset in the middle of a transfer.
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_level", {27'd0, level}, 9);
    @(negedge clk);
    #2;
    wr = 1'b1; w_data = 8'hDD; rd = 1'b1; clr_err = 1'b0;
    #1 rst_n = 1'b0;
    #1 reset_vals("async_rst");
    @(posedge clk);
    #1 reset_vals("held_rst");
    @(negedge clk);
    #2;
    rst_n = 1'b1; wr = 1'b0; rd = 1'b0;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("post_rst_level", {27'd0, level}, 1);
`ifdef UART_FIFO_FWFT_EN
    chk("post_rst_data", r_data, 8'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`else
    chk("post_rst_rvalid", r_valid, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_data", r_data, 8'hA5);
    chk("post_rst_rvalid1", r_valid, 1'b1);
`endif
    chk("post_rst_empty", empty, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
